// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver.
// Shows a 32-bit word as hex digits. The word is double-buffered and only
// swapped at a frame boundary, so the display never shows a mix of two words.
// Each digit slot starts with a short all-anodes-off window to stop ghosting.
// Leading zero digits can be suppressed.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        lz_blank,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic             frame_end;
  logic [31:0]      shown;
  logic [31:0]      pend_data;
  logic [IDX_W-1:0] msd;
  logic [3:0]       nib;
  logic             digit_on;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot divider and digit index: div walks the slot, idx advances on slot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Last cycle of the last digit slot
  always_comb begin
    frame_end = (div == DIV_LAST) && (idx == IDX_LAST);
  end

  // Frame-boundary marker, one cycle after frame_end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= frame_end;
  end

  // Double buffer: a load coinciding with frame_end bypasses the pending stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown     <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
    end else begin
      if (load) pend_data <= data_in;
      if (frame_end && load) begin
        shown   <= data_in;
        pending <= 1'b0;
      end else if (frame_end && pending) begin
        shown   <= pend_data;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Most significant nonzero digit of the displayed word (0 when word is 0)
  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (shown[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
  end

  // Current nibble and whether this slot drives its digit at all
  always_comb begin
    nib      = shown[4*idx +: 4];
    digit_on = (div >= BLANK_END) && !(lz_blank && (idx > msd));
  end

  // Registered panel drive; all-off during anti-ghost window or blanked digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (!digit_on) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= hex7(nib);
      dp  <= ~dp_mask[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan (8 cycles/slot, 2 blank).
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;   // rising edges since reset release, sampled on falling edge

  logic [6:0] hex_t [16];

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .DIGITS   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load      (load),
    .lz_blank  (lz_blank),
    .dp_mask   (dp_mask),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Advance one clock; at most one anode may be low at any time
  task automatic tick();
    @(negedge clk);
    t++;
    chk("an_onehot0", 32'($countones(~an) <= 1), 32'd1);
  endtask

  // Expected {an, seg, dp} for the counter value c
  function automatic logic [15:0] model(input int c, input logic [31:0] sh,
                                        input logic lzb, input logic [7:0] dpm);
    int d;
    int i;
    int msd;
    logic [7:0] one;
    d   = c % 8;
    i   = (c / 8) % 8;
    msd = 0;
    one = 8'd1;
    for (int k = 0; k < 8; k++) if (sh[4*k +: 4] != 4'h0) msd = k;
    if (d < int'(BLANK_CYC) || (lzb && i > msd)) return {8'hFF, 7'h7F, 1'b1};
    return {~(one << i), hex_t[sh[4*i +: 4]], ~dpm[i]};
  endfunction

  // One full frame with the given displayed word; optional loads at offsets la/lb
  task automatic run_frame(input logic [31:0] sh, input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb);
    int base;
    int act [8];
    logic pend;
    logic [15:0] e;
    logic [7:0] one;
    base = t;
    pend = 1'b0;
    one  = 8'd1;
    for (int k = 0; k < 8; k++) act[k] = 0;
    for (int o = 0; o < 64; o++) begin
      if (o == la) begin load = 1'b1; data_in = va; end
      else if (o == lb) begin load = 1'b1; data_in = vb; end
      tick();
      if (load) pend = 1'b1;
      if (o == 63) pend = 1'b0;
      load = 1'b0;
      e = model(base + o, sh, lz_blank, dp_mask);
      chk("an", 32'(an), 32'(e[15:8]));
      chk("seg", 32'(seg), 32'(e[7:1]));
      chk("dp", 32'(dp), 32'(e[0]));
      chk("pending", 32'(pending), 32'(pend));
      chk("frame_done", 32'(frame_done), (o == 63) ? 32'd1 : 32'd0);
      for (int k = 0; k < 8; k++) if (an == ~(one << k)) act[k]++;
    end
    for (int k = 0; k < 8; k++) begin
      e = model(base + 8*k + 7, sh, lz_blank, dp_mask);
      chk("active_cycles", 32'(act[k]), (e[15:8] != 8'hFF) ? 32'd6 : 32'd0);
    end
  endtask

  initial begin
    hex_t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Asynchronous reset asserted mid-cycle: outputs idle before any edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;

    // Frame 0: shows zero; load 1234ABCD at cycle 5
    run_frame(32'h0, 5, 32'h1234ABCD, -1, 32'h0);
    // Frame 1: 1234ABCD with dp on digit 2; load FFFFFFFF exactly on frame_end
    dp_mask = 8'h04;
    run_frame(32'h1234ABCD, 63, 32'hFFFFFFFF, -1, 32'h0);
    // Frame 2: all F; two loads, only the second must survive
    run_frame(32'hFFFFFFFF, 10, 32'h11111111, 40, 32'h22222222);
    // Frame 3: 22222222 with leading-zero suppression on (no zeros to drop)
    lz_blank = 1'b1;
    run_frame(32'h22222222, 20, 32'h000000A5, -1, 32'h0);
    // Frame 4: 000000A5 -> only digits 0 and 1 lit
    run_frame(32'h000000A5, 30, 32'h00000000, -1, 32'h0);
    // Frame 5: zero word -> digit 0 still shows 0
    run_frame(32'h00000000, -1, 32'h0, -1, 32'h0);

    // Mid-frame reset with a pending word: everything idles at once
    load = 1'b1;
    data_in = 32'h12345678;
    tick();
    load = 1'b0;
    chk("pending_before_rst", 32'(pending), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'hFF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'd1);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    lz_blank = 1'b0;
    // Pending word was discarded: two frames of zeros
    run_frame(32'h0, -1, 32'h0, -1, 32'h0);
    run_frame(32'h0, -1, 32'h0, -1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
